// File: rtl/unidad_busqueda_if.sv
// unidad_busqueda_if: memory, redirect and decode-side handshake signals of the fetch unit
interface unidad_busqueda_if;
  logic [31:0] dir;
  logic [31:0] instr_mem;
  logic        salto_valido;
  logic [31:0] dir_salto;
  logic        listo;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valido;
  logic        alto;
  logic        falla;
  logic [15:0] num_entregadas;
  modport master (
    output dir, instr_out, pc_out, valido, alto, falla, num_entregadas,
    input  instr_mem, salto_valido, dir_salto, listo
  );
  modport slave (
    input  dir, instr_out, pc_out, valido, alto, falla, num_entregadas,
    output instr_mem, salto_valido, dir_salto, listo
  );
endinterface

// File: rtl/unidad_busqueda.sv
// unidad_busqueda: instruction-fetch sequencer with one-entry valid/ready output stage,
// redirects, end-of-memory halt and sticky misaligned/out-of-range redirect fault
module unidad_busqueda #(
  parameter int PC_INICIAL = 0,
  parameter int LIMITE_MEM = 256
) (
  input logic clk,
  input logic reset,
  unidad_busqueda_if.master bus
);
  typedef enum logic [1:0] {BUSCAR, FIN, FALLA} estado_t;
  estado_t     r_estado, w_estado;
  logic [31:0] r_pc, w_pc;
  logic [31:0] r_instr, w_instr;
  logic [31:0] r_pc_out, w_pc_out;
  logic        r_valido, w_valido;
  logic        r_alto, w_alto;
  logic        r_falla, w_falla;
  logic [15:0] r_cnt;
  logic        w_xfer, w_carga, w_mala;
  assign w_xfer  = r_valido && bus.listo;
  assign w_carga = !r_valido || bus.listo;
  assign w_mala  = (|bus.dir_salto[1:0]) || (bus.dir_salto >= 32'(LIMITE_MEM));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado <= BUSCAR;
      r_pc     <= 32'(PC_INICIAL);
      r_instr  <= '0;
      r_pc_out <= '0;
      r_valido <= 1'b0;
      r_alto   <= 1'b0;
      r_falla  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_estado <= w_estado;
      r_pc     <= w_pc;
      r_instr  <= w_instr;
      r_pc_out <= w_pc_out;
      r_valido <= w_valido;
      r_alto   <= w_alto;
      r_falla  <= w_falla;
      r_cnt    <= r_cnt + 16'(w_xfer);
    end
  end
  // Redirect outranks loading; a transfer in the redirect cycle is still counted above
  always_comb begin
    w_estado = r_estado;
    w_pc     = r_pc;
    w_instr  = r_instr;
    w_pc_out = r_pc_out;
    w_valido = r_valido;
    w_alto   = r_alto;
    w_falla  = r_falla;
    if (r_estado == FALLA) begin
      w_valido = 1'b0;
      w_falla  = 1'b1;
    end else if (bus.salto_valido) begin
      w_valido = 1'b0;
      if (w_mala) begin
        w_estado = FALLA;
        w_falla  = 1'b1;
      end else begin
        w_pc     = bus.dir_salto;
        w_alto   = 1'b0;
        w_estado = BUSCAR;
      end
    end else if (r_estado == BUSCAR && w_carga) begin
      w_instr  = bus.instr_mem;
      w_pc_out = r_pc;
      w_valido = 1'b1;
      w_pc     = r_pc + 32'd4;
      if (r_pc == 32'(LIMITE_MEM - 4)) begin
        w_estado = FIN;
        w_alto   = 1'b1;
      end
    end else if (r_estado == FIN && w_xfer) begin
      w_valido = 1'b0;
    end
  end
  assign bus.dir            = r_pc;
  assign bus.instr_out      = r_instr;
  assign bus.pc_out         = r_pc_out;
  assign bus.valido         = r_valido;
  assign bus.alto           = r_alto;
  assign bus.falla          = r_falla;
  assign bus.num_entregadas = r_cnt;
endmodule

// File: tb/tb_unidad_busqueda.sv
// tb_unidad_busqueda: directed fetch, backpressure, redirect, fault, end-of-memory and reset vectors
module tb_unidad_busqueda;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [7:0] mem [0:255];
  logic [7:0] a;
  unidad_busqueda_if bus();
  unidad_busqueda #(.PC_INICIAL(0), .LIMITE_MEM(256)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign a = bus.dir[7:0];
  assign bus.instr_mem = {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put_word(input int addr, input logic [31:0] w);
    {mem[addr], mem[addr + 1], mem[addr + 2], mem[addr + 3]} = w;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.salto_valido = 1'b0;
    tick();
    reset = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 256; i += 4) put_word(i, 32'hA000_0000 | 32'(i));
    put_word(0, 32'h014A1820);
    put_word(4, 32'h004D5820);
    put_word(8, 32'h000D4A02);
    bus.salto_valido = 1'b0;
    bus.dir_salto = '0;
    bus.listo = 1'b1;
    tick();
    tick();
    chk("rst_valido", 32'(bus.valido), 0);
    chk("rst_instr", bus.instr_out, 0);
    chk("rst_pc_out", bus.pc_out, 0);
    chk("rst_dir", bus.dir, 0);
    chk("rst_alto", 32'(bus.alto), 0);
    chk("rst_falla", 32'(bus.falla), 0);
    chk("rst_cnt", 32'(bus.num_entregadas), 0);
    reset = 1'b0;
    tick();
    chk("seq0_valido", 32'(bus.valido), 1);
    chk("seq0_instr", bus.instr_out, 32'h014A1820);
    chk("seq0_pc", bus.pc_out, 0);
    chk("seq0_dir", bus.dir, 4);
    tick();
    chk("seq1_instr", bus.instr_out, 32'h004D5820);
    chk("seq1_pc", bus.pc_out, 4);
    chk("seq1_cnt", 32'(bus.num_entregadas), 1);
    tick();
    chk("seq2_instr", bus.instr_out, 32'h000D4A02);
    chk("seq2_pc", bus.pc_out, 8);
    tick();
    chk("seq3_cnt", 32'(bus.num_entregadas), 3);
    chk("seq3_pc", bus.pc_out, 32'hC);
    do_reset();
    tick();
    bus.listo = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_instr", bus.instr_out, 32'h014A1820);
      chk("bp_pc", bus.pc_out, 0);
      chk("bp_dir", bus.dir, 4);
      chk("bp_cnt", 32'(bus.num_entregadas), 0);
      chk("bp_valido", 32'(bus.valido), 1);
    end
    bus.listo = 1'b1;
    tick();
    chk("bp_resume_pc", bus.pc_out, 4);
    chk("bp_resume_cnt", 32'(bus.num_entregadas), 1);
    bus.listo = 1'b0;
    tick();
    chk("hold4_pc", bus.pc_out, 4);
    bus.salto_valido = 1'b1;
    bus.dir_salto = 32'h10;
    tick();
    bus.salto_valido = 1'b0;
    bus.listo = 1'b1;
    chk("rd_bubble", 32'(bus.valido), 0);
    chk("rd_dir", bus.dir, 32'h10);
    chk("rd_cnt", 32'(bus.num_entregadas), 1);
    tick();
    chk("rd_valido", 32'(bus.valido), 1);
    chk("rd_pc", bus.pc_out, 32'h10);
    chk("rd_instr", bus.instr_out, 32'hA000_0010);
    chk("rd_cnt2", 32'(bus.num_entregadas), 1);
    bus.salto_valido = 1'b1;
    bus.dir_salto = 32'h6;
    tick();
    chk("mis_falla", 32'(bus.falla), 1);
    chk("mis_valido", 32'(bus.valido), 0);
    chk("mis_cnt", 32'(bus.num_entregadas), 2);
    bus.dir_salto = 32'h0;
    tick();
    tick();
    bus.salto_valido = 1'b0;
    chk("mis_ign_falla", 32'(bus.falla), 1);
    chk("mis_ign_valido", 32'(bus.valido), 0);
    chk("mis_ign_dir", bus.dir, 32'h14);
    tick();
    chk("mis_stay_valido", 32'(bus.valido), 0);
    do_reset();
    chk("mis_rst_falla", 32'(bus.falla), 0);
    chk("mis_rst_cnt", 32'(bus.num_entregadas), 0);
    bus.salto_valido = 1'b1;
    bus.dir_salto = 32'h100;
    tick();
    bus.salto_valido = 1'b0;
    chk("oor_falla", 32'(bus.falla), 1);
    chk("oor_valido", 32'(bus.valido), 0);
    chk("oor_dir", bus.dir, 0);
    tick();
    chk("oor_stay_valido", 32'(bus.valido), 0);
    do_reset();
    bus.salto_valido = 1'b1;
    bus.dir_salto = 32'hF8;
    tick();
    bus.salto_valido = 1'b0;
    chk("end_bubble", 32'(bus.valido), 0);
    chk("end_dir", bus.dir, 32'hF8);
    tick();
    chk("end_pcF8", bus.pc_out, 32'hF8);
    chk("end_alto0", 32'(bus.alto), 0);
    tick();
    chk("end_pcFC", bus.pc_out, 32'hFC);
    chk("end_instrFC", bus.instr_out, 32'hA000_00FC);
    chk("end_alto1", 32'(bus.alto), 1);
    chk("end_valido1", 32'(bus.valido), 1);
    tick();
    chk("end_drain_valido", 32'(bus.valido), 0);
    chk("end_drain_cnt", 32'(bus.num_entregadas), 2);
    chk("end_dir_frozen", bus.dir, 32'h100);
    tick();
    chk("end_still_idle", 32'(bus.valido), 0);
    chk("end_still_alto", 32'(bus.alto), 1);
    bus.salto_valido = 1'b1;
    bus.dir_salto = 32'h0;
    tick();
    bus.salto_valido = 1'b0;
    chk("end_rd_alto", 32'(bus.alto), 0);
    chk("end_rd_dir", bus.dir, 0);
    tick();
    chk("end_rd_valido", 32'(bus.valido), 1);
    chk("end_rd_pc", bus.pc_out, 0);
    chk("end_rd_instr", bus.instr_out, 32'h014A1820);
    tick();
    reset = 1'b1;
    bus.salto_valido = 1'b1;
    bus.dir_salto = 32'h20;
    tick();
    reset = 1'b0;
    bus.salto_valido = 1'b0;
    chk("rs_dir", bus.dir, 0);
    chk("rs_valido", 32'(bus.valido), 0);
    chk("rs_cnt", 32'(bus.num_entregadas), 0);
    chk("rs_falla", 32'(bus.falla), 0);
    tick();
    chk("rs_first_pc", bus.pc_out, 0);
    chk("rs_first_valido", 32'(bus.valido), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
